regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between
// source 0 (ALU/immediate results) and source 1 (load data).
// Round-robin tie break by default; define WBARB_FIXED_PRIO_EN for fixed
// priority (source 0 always wins a tie, source 1 may starve).
// Registered write-back stage plus a saturating stall counter.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [ADDRESS_WIDTH-1:0] s0_dest,
  input  logic [DATA_WIDTH-1:0]    s0_data,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic [ADDRESS_WIDTH-1:0] s1_dest,
  input  logic [DATA_WIDTH-1:0]    s1_data,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic [CNT_WIDTH-1:0]     stall_cnt
);

  // last_gnt_q: 1 means source 1 was granted last, so source 0 wins the next tie
  logic                     last_gnt_q, last_gnt_d;
  logic                     regwrite_q, regwrite_d;
  logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [CNT_WIDTH-1:0]     stall_q, stall_d;
  logic                     gnt0_c, gnt1_c;

  // Grant decision; no grants while reset is held
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
`ifdef WBARB_FIXED_PRIO_EN
    gnt0_c = rst & s0_valid;
    gnt1_c = rst & s1_valid & ~s0_valid;
`else
    gnt0_c = rst & s0_valid & (~s1_valid | last_gnt_q);
    gnt1_c = rst & s1_valid & (~s0_valid | ~last_gnt_q);
`endif
  end

  assign s0_ready = gnt0_c;
  assign s1_ready = gnt1_c;

  // Next-state for priority, write-back stage and stall counter
  always_comb begin
    last_gnt_d = last_gnt_q;
    regwrite_d = 1'b0;
    dest_d     = dest_q;
    data_d     = data_q;
    stall_d    = stall_q;
    if (gnt0_c) begin
      dest_d     = s0_dest;
      data_d     = s0_data;
      regwrite_d = (s0_dest != ADDRESS_WIDTH'(0));
`ifndef WBARB_FIXED_PRIO_EN
      last_gnt_d = 1'b0;
`endif
    end else if (gnt1_c) begin
      dest_d     = s1_dest;
      data_d     = s1_data;
      regwrite_d = (s1_dest != ADDRESS_WIDTH'(0));
`ifndef WBARB_FIXED_PRIO_EN
      last_gnt_d = 1'b1;
`endif
    end
    if (s0_valid && s1_valid && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt_q <= 1'b1;
      regwrite_q <= 1'b0;
      dest_q     <= '0;
      data_q     <= '0;
      stall_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      regwrite_q <= regwrite_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      stall_q    <= stall_d;
    end
  end

  assign RegWrite    = regwrite_q;
  assign rg_wrt_dest = dest_q;
  assign rg_wrt_data = data_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (both WBARB_FIXED_PRIO_EN builds).
module tb_regfile_wb_arbiter;

`ifdef WBARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_dest, s1_dest;
  logic [31:0] s0_data, s1_data;
  logic        reg_write;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  logic [15:0] stall_cnt;

  logic        r0_4, r1_4, rw_4;
  logic [4:0]  dest_4;
  logic [31:0] data_4;
  logic [3:0]  stall_4;

  int total = 0;
  int bad   = 0;
  bit exp0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_dest(s0_dest), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_dest(s1_dest), .s1_data(s1_data),
    .RegWrite(reg_write), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .stall_cnt(stall_cnt)
  );

  regfile_wb_arbiter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(r0_4), .s0_dest(s0_dest), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(r1_4), .s1_dest(s1_dest), .s1_data(s1_data),
    .RegWrite(rw_4), .rg_wrt_dest(dest_4), .rg_wrt_data(data_4),
    .stall_cnt(stall_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both sources requesting
    rst = 1'b0;
    s0_valid = 1'b1; s0_dest = 5'd3; s0_data = 32'hA0A0_0000;
    s1_valid = 1'b1; s1_dest = 5'd4; s1_data = 32'hB1B1_1111;
    #1;
    check("rst_rdy0", 32'(s0_ready), 32'd0);
    check("rst_rdy1", 32'(s1_ready), 32'd0);
    tick(); tick();
    check("rst_we",    32'(reg_write),   32'd0);
    check("rst_dest",  32'(rg_wrt_dest), 32'd0);
    check("rst_data",  rg_wrt_data,      32'd0);
    check("rst_stall", 32'(stall_cnt),   32'd0);
    check("rst_rdy0b", 32'(s0_ready),    32'd0);
    check("rst_rdy1b", 32'(s1_ready),    32'd0);

    // Continuous contention from reset release
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp0 = FIXED ? 1'b1 : (i % 2 == 0);
      #1;
      check($sformatf("cont_rdy0_%0d", i), 32'(s0_ready), 32'(exp0));
      check($sformatf("cont_rdy1_%0d", i), 32'(s1_ready), 32'(!exp0));
      tick();
      check($sformatf("cont_we_%0d", i),    32'(reg_write),   32'd1);
      check($sformatf("cont_dest_%0d", i),  32'(rg_wrt_dest), exp0 ? 32'd3 : 32'd4);
      check($sformatf("cont_data_%0d", i),  rg_wrt_data,      exp0 ? 32'hA0A0_0000 : 32'hB1B1_1111);
      check($sformatf("cont_stall_%0d", i), 32'(stall_cnt),   32'(i + 1));
    end

    // Idle: no write, address/data hold
    s0_valid = 1'b0; s1_valid = 1'b0;
    #1;
    check("idle_rdy0", 32'(s0_ready), 32'd0);
    check("idle_rdy1", 32'(s1_ready), 32'd0);
    tick();
    check("idle_we",   32'(reg_write),   32'd0);
    check("idle_dest", 32'(rg_wrt_dest), FIXED ? 32'd3 : 32'd4);

    // Single source 1
    s1_valid = 1'b1; s1_dest = 5'd5; s1_data = 32'hDEAD_BEEF;
    #1;
    check("single_rdy1", 32'(s1_ready), 32'd1);
    check("single_rdy0", 32'(s0_ready), 32'd0);
    tick();
    check("single_we",    32'(reg_write),   32'd1);
    check("single_dest",  32'(rg_wrt_dest), 32'd5);
    check("single_data",  rg_wrt_data,      32'hDEAD_BEEF);
    check("single_stall", 32'(stall_cnt),   32'd4);
    s1_valid = 1'b0;
    tick();
    check("single_we_off", 32'(reg_write),   32'd0);
    check("single_hold",   32'(rg_wrt_dest), 32'd5);

    // Write to x0 is accepted but discarded
    s0_valid = 1'b1; s0_dest = 5'd0; s0_data = 32'h0000_1234;
    #1;
    check("x0_rdy0", 32'(s0_ready), 32'd1);
    tick();
    check("x0_we",   32'(reg_write), 32'd0);
    check("x0_data", rg_wrt_data,    32'h0000_1234);

    // Tie after x0 grant: last_gnt is 0, so source 1 wins (round-robin)
    s0_dest = 5'd8; s0_data = 32'h0000_0088;
    s1_valid = 1'b1; s1_dest = 5'd9; s1_data = 32'h0000_0099;
    #1;
    check("tie_rdy1", 32'(s1_ready), FIXED ? 32'd0 : 32'd1);
    check("tie_rdy0", 32'(s0_ready), FIXED ? 32'd1 : 32'd0);
    tick();
    check("tie_we",    32'(reg_write),   32'd1);
    check("tie_dest",  32'(rg_wrt_dest), FIXED ? 32'd8 : 32'd9);
    check("tie_stall", 32'(stall_cnt),   32'd5);

    // Reset while a write to x7 sits in the output stage
    s1_valid = 1'b0; s0_dest = 5'd7; s0_data = 32'h0000_0077;
    #1;
    check("mid_rdy0", 32'(s0_ready), 32'd1);
    tick();
    check("mid_we",   32'(reg_write),   32'd1);
    check("mid_dest", 32'(rg_wrt_dest), 32'd7);
    rst = 1'b0;
    #1;
    check("mid_rst_rdy0", 32'(s0_ready), 32'd0);
    tick();
    check("mid_rst_we",    32'(reg_write),   32'd0);
    check("mid_rst_dest",  32'(rg_wrt_dest), 32'd0);
    check("mid_rst_data",  rg_wrt_data,      32'd0);
    check("mid_rst_stall", 32'(stall_cnt),   32'd0);

    // Long contention: first tie goes to s0, counters count / saturate
    rst = 1'b1;
    s0_dest = 5'd3; s0_data = 32'hA0A0_0000;
    s1_valid = 1'b1; s1_dest = 5'd4; s1_data = 32'hB1B1_1111;
    for (int i = 0; i < 20; i++) begin
      exp0 = FIXED ? 1'b1 : (i % 2 == 0);
      #1;
      check($sformatf("sat_rdy0_%0d", i), 32'(s0_ready), 32'(exp0));
      tick();
      check($sformatf("sat_stall16_%0d", i), 32'(stall_cnt), 32'(i + 1));
      check($sformatf("sat_stall4_%0d", i),  32'(stall_4),   (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
